// File: rtl/stream_pool2d_if.sv
// Valid/ready bundle for stream_pool2d: pixel input stream and pooled result stream.
interface stream_pool2d_if #(
  parameter int unsigned WIDTH = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/stream_pool2d.sv
// Streaming non-overlapping POOLxPOOL max/avg pooling over a raster-order pixel stream.
module stream_pool2d #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned POOL   = 2,
  parameter bit          SIGNED = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_mode,
  stream_pool2d_if.slave bus
);
  localparam int unsigned PL    = $clog2(POOL);
  localparam int unsigned SUM_W = WIDTH + 2 * PL;
  localparam int unsigned OUT_W = IMG_W / POOL;
  localparam int unsigned OUT_H = IMG_H / POOL;
  localparam int unsigned CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned GW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             mode_r;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] line_buf [OUT_W];

  logic             accept, first_px, mode_eff, in_region;
  logic             grp_end, band_first, band_end, win_done, win_last;
  logic [PL-1:0]    cx, ry;
  logic [GW-1:0]    grp;
  logic [SUM_W-1:0] pix_ext, row_val, band_val, avg_val;
  logic [WIDTH-1:0] result;

  function automatic logic [SUM_W-1:0] combine(input logic avg,
                                               input logic [SUM_W-1:0] a,
                                               input logic [SUM_W-1:0] b);
    logic a_gt_b;
    if (SIGNED) a_gt_b = $signed(a) > $signed(b);
    else        a_gt_b = a > b;
    if (avg)         combine = a + b;
    else if (a_gt_b) combine = a;
    else             combine = b;
  endfunction

  assign bus.s_ready = !bus.m_valid || bus.m_ready;
  assign accept      = bus.s_valid && bus.s_ready;
  assign first_px    = (col == '0) && (row == '0);
  // The frame's first pixel already uses the incoming mode, before mode_r captures it.
  assign mode_eff    = first_px ? i_mode : mode_r;
  assign in_region   = (32'(col) < OUT_W * POOL) && (32'(row) < OUT_H * POOL);
  assign cx          = col[PL-1:0];
  assign ry          = row[PL-1:0];
  assign grp         = GW'(col >> PL);
  assign grp_end     = (cx == '1);
  assign band_first  = (ry == '0);
  assign band_end    = (ry == '1);
  assign win_done    = accept && in_region && grp_end && band_end;
  assign win_last    = (32'(col) == OUT_W * POOL - 1) && (32'(row) == OUT_H * POOL - 1);

  always_comb begin
    pix_ext  = '0;
    row_val  = '0;
    band_val = '0;
    avg_val  = '0;
    result   = '0;
    if (SIGNED) pix_ext = {{(SUM_W - WIDTH){bus.s_data[WIDTH-1]}}, bus.s_data};
    else        pix_ext = {{(SUM_W - WIDTH){1'b0}}, bus.s_data};
    row_val  = (cx == '0) ? pix_ext : combine(mode_eff, acc, pix_ext);
    band_val = band_first ? row_val : combine(mode_eff, line_buf[grp], row_val);
    if (SIGNED) avg_val = SUM_W'($signed(band_val) >>> (2 * PL));
    else        avg_val = band_val >> (2 * PL);
    result   = mode_eff ? avg_val[WIDTH-1:0] : band_val[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col    <= '0;
      row    <= '0;
      mode_r <= 1'b0;
    end else if (accept) begin
      if (first_px) mode_r <= i_mode;
      if (32'(col) == IMG_W - 1) begin
        col <= '0;
        row <= (32'(row) == IMG_H - 1) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Datapath storage needs no reset: the first pixel of a group and the first row of a band overwrite it.
  always_ff @(posedge clk) begin
    if (accept && in_region) begin
      acc <= row_val;
      if (grp_end) line_buf[grp] <= band_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_last  <= 1'b0;
    end else if (win_done) begin
      bus.m_valid <= 1'b1;
      bus.m_data  <= result;
      bus.m_last  <= win_last;
    end else if (bus.m_ready) begin
      bus.m_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_pool2d.sv
// Directed bench for stream_pool2d: 4x4 unsigned, 2x2 signed and 5x5 unsigned instances.
module tb_stream_pool2d;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mode4 = 1'b0, modes = 1'b0, mode5 = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  stream_pool2d_if #(.WIDTH(8)) b4 ();
  stream_pool2d_if #(.WIDTH(8)) bs ();
  stream_pool2d_if #(.WIDTH(8)) b5 ();

  stream_pool2d #(.WIDTH(8), .IMG_W(4), .IMG_H(4), .POOL(2), .SIGNED(1'b0)) u4 (
    .clk(clk), .rst(rst), .i_mode(mode4), .bus(b4));
  stream_pool2d #(.WIDTH(8), .IMG_W(2), .IMG_H(2), .POOL(2), .SIGNED(1'b1)) us (
    .clk(clk), .rst(rst), .i_mode(modes), .bus(bs));
  stream_pool2d #(.WIDTH(8), .IMG_W(5), .IMG_H(5), .POOL(2), .SIGNED(1'b0)) u5 (
    .clk(clk), .rst(rst), .i_mode(mode5), .bus(b5));

  task automatic test_reset;
    b4.s_valid = 1'b0; b4.s_data = '0; b4.m_ready = 1'b1;
    bs.s_valid = 1'b0; bs.s_data = '0; bs.m_ready = 1'b1;
    b5.s_valid = 1'b0; b5.s_data = '0; b5.m_ready = 1'b1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (b4.m_valid !== 1'b0 || b4.m_data !== 8'd0 || b4.m_last !== 1'b0 || b4.s_ready !== 1'b1)
      $display("FAIL reset4: got v=%b d=%0d l=%b rdy=%b, want v=0 d=0 l=0 rdy=1",
               b4.m_valid, b4.m_data, b4.m_last, b4.s_ready);
    else passed++;
    total++;
    if (bs.m_valid !== 1'b0 || bs.m_data !== 8'd0 || b5.m_valid !== 1'b0 || b5.s_ready !== 1'b1)
      $display("FAIL reset_other: got vs=%b ds=%0d v5=%b rdy5=%b, want 0 0 0 1",
               bs.m_valid, bs.m_data, b5.m_valid, b5.s_ready);
    else passed++;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One full 4x4 frame of pixels 0..15 with m_ready high; checks every cycle.
  task automatic run_frame4(input string name, input logic mode0, input logic mode_rest,
                            input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] ex [4];
    int k;
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    k = 0;
    b4.m_ready = 1'b1;
    for (int p = 0; p < 16; p++) begin
      mode4 = (p == 0) ? mode0 : mode_rest;
      b4.s_valid = 1'b1;
      b4.s_data  = 8'(p);
      @(posedge clk);
      #1;
      total++;
      if (p == 5 || p == 7 || p == 13 || p == 15) begin
        if (b4.m_valid !== 1'b1 || b4.m_data !== ex[k] || b4.m_last !== 1'(k == 3))
          $display("FAIL %s win%0d: got v=%b d=%0d l=%b, want v=1 d=%0d l=%b",
                   name, k, b4.m_valid, b4.m_data, b4.m_last, ex[k], (k == 3));
        else passed++;
        k++;
      end else begin
        if (b4.m_valid !== 1'b0)
          $display("FAIL %s idle_px%0d: got m_valid=%b, want 0", name, p, b4.m_valid);
        else passed++;
      end
    end
    b4.s_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_max;
    run_frame4("max4", 1'b0, 1'b0, 8'd5, 8'd7, 8'd13, 8'd15);
  endtask

  task automatic test_avg;
    run_frame4("avg4", 1'b1, 1'b1, 8'd2, 8'd4, 8'd10, 8'd12);
  endtask

  task automatic test_backpressure;
    logic [7:0] ex [4];
    int p, got, hold;
    logic started;
    ex[0] = 8'd5; ex[1] = 8'd7; ex[2] = 8'd13; ex[3] = 8'd15;
    p = 0; got = 0; hold = 0; started = 1'b0;
    mode4 = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      b4.s_valid = (p < 16);
      b4.s_data  = 8'(p);
      if (b4.m_valid && !started) begin
        started = 1'b1;
        hold = 5;
      end
      b4.m_ready = (hold == 0);
      #1;
      if (hold > 0) begin
        total++;
        if (b4.s_ready !== 1'b0 || b4.m_valid !== 1'b1 || b4.m_data !== 8'd5)
          $display("FAIL bp_hold%0d: got rdy=%b v=%b d=%0d, want rdy=0 v=1 d=5",
                   hold, b4.s_ready, b4.m_valid, b4.m_data);
        else passed++;
        hold--;
      end
      if (b4.m_valid && b4.m_ready) begin
        total++;
        if (b4.m_data !== ex[got] || b4.m_last !== 1'(got == 3))
          $display("FAIL bp_out%0d: got d=%0d l=%b, want d=%0d l=%b",
                   got, b4.m_data, b4.m_last, ex[got], (got == 3));
        else passed++;
        got++;
      end
      if (b4.s_valid && b4.s_ready) p++;
      @(posedge clk);
      #1;
    end
    b4.s_valid = 1'b0;
    b4.m_ready = 1'b1;
    total++;
    if (got != 4 || p != 16)
      $display("FAIL bp_count: got results=%0d pixels=%0d, want results=4 pixels=16", got, p);
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame_s(input string name, input logic mode,
                             input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input logic [7:0] p3,
                             input logic [7:0] expv);
    logic [7:0] px [4];
    px[0] = p0; px[1] = p1; px[2] = p2; px[3] = p3;
    modes = mode;
    bs.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bs.s_valid = 1'b1;
      bs.s_data  = px[i];
      @(posedge clk);
      #1;
      total++;
      if (i < 3) begin
        if (bs.m_valid !== 1'b0)
          $display("FAIL %s idle_px%0d: got m_valid=%b, want 0", name, i, bs.m_valid);
        else passed++;
      end else begin
        if (bs.m_valid !== 1'b1 || bs.m_data !== expv || bs.m_last !== 1'b1)
          $display("FAIL %s result: got v=%b d=%h l=%b, want v=1 d=%h l=1",
                   name, bs.m_valid, bs.m_data, bs.m_last, expv);
        else passed++;
      end
    end
    bs.s_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_signed;
    run_frame_s("signed_max", 1'b0, 8'hFF, 8'h80, 8'hFB, 8'hFE, 8'hFF);
    run_frame_s("signed_avg", 1'b1, 8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFD);
  endtask

  task automatic run_frame5(input string name, input int base);
    int k;
    k = 0;
    mode5 = 1'b0;
    b5.m_ready = 1'b1;
    for (int p = 0; p < 25; p++) begin
      b5.s_valid = 1'b1;
      b5.s_data  = 8'(base + p);
      @(posedge clk);
      #1;
      total++;
      if (p == 6 || p == 8 || p == 16 || p == 18) begin
        if (b5.m_valid !== 1'b1 || b5.m_data !== 8'(base + p) || b5.m_last !== 1'(k == 3))
          $display("FAIL %s win%0d: got v=%b d=%0d l=%b, want v=1 d=%0d l=%b",
                   name, k, b5.m_valid, b5.m_data, b5.m_last, base + p, (k == 3));
        else passed++;
        k++;
      end else begin
        if (b5.m_valid !== 1'b0)
          $display("FAIL %s idle_px%0d: got m_valid=%b, want 0", name, p, b5.m_valid);
        else passed++;
      end
    end
    b5.s_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignored_edges;
    run_frame5("edge5_f1", 0);
    run_frame5("edge5_f2", 100);
  endtask

  task automatic test_reset_mid_frame;
    mode4 = 1'b0;
    b4.m_ready = 1'b1;
    for (int p = 0; p < 6; p++) begin
      b4.s_valid = 1'b1;
      b4.s_data  = 8'(200 + p);
      @(posedge clk);
      #1;
    end
    total++;
    if (b4.m_valid !== 1'b1 || b4.m_data !== 8'd205)
      $display("FAIL pre_reset: got v=%b d=%0d, want v=1 d=205", b4.m_valid, b4.m_data);
    else passed++;
    b4.s_valid = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if (b4.m_valid !== 1'b0 || b4.s_ready !== 1'b1 || b4.m_data !== 8'd0)
      $display("FAIL async_reset: got v=%b rdy=%b d=%0d, want v=0 rdy=1 d=0",
               b4.m_valid, b4.s_ready, b4.m_data);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_frame4("post_reset_toggle", 1'b0, 1'b1, 8'd5, 8'd7, 8'd13, 8'd15);
    run_frame4("mode_next_frame", 1'b1, 1'b0, 8'd2, 8'd4, 8'd10, 8'd12);
  endtask

  initial begin
    test_reset();
    test_max();
    test_avg();
    test_backpressure();
    test_signed();
    test_ignored_edges();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end
endmodule
